// File: rtl/mem_fill_responder.sv
// Fixed-latency 16-bit word memory that answers fill reads through a pipelined
// {valid, data} shift register; writes commit immediately and return nothing.
module mem_fill_responder #(
    parameter int LATENCY   = 4,
    parameter int WORD_BITS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [2:0]  pending
);

    localparam int DEPTH = 1 << WORD_BITS;

    logic [15:0]          mem_q [DEPTH];
    logic [WORD_BITS-1:0] word_idx;
    logic                 rd_acc;
    logic                 wr_acc;

    logic [LATENCY-1:0]   vld_q;
    logic [LATENCY-1:0]   vld_d;
    logic [15:0]          dat_q [LATENCY];
    logic [15:0]          dat_d [LATENCY];
    logic [2:0]           pending_q;
    logic [2:0]           pending_d;

    // Byte-lane bit and bits above the word index are don't-care.
    logic [15:0]          unused_addr_bits;
    assign unused_addr_bits = addr & ~(16'(DEPTH - 1) << 1);

    assign word_idx = addr[WORD_BITS:1];
    assign rd_acc   = enable & ~wr & ~rst;
    assign wr_acc   = enable &  wr & ~rst;

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[word_idx] <= data_in;
        end
    end

    always_comb begin
        vld_d    = '0;
        dat_d    = '{default: '0};
        vld_d[0] = rd_acc;
        dat_d[0] = rd_acc ? mem_q[word_idx] : 16'h0000;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_comb begin
        pending_d = pending_q;
        case ({rd_acc, vld_q[LATENCY-1]})
            2'b10:   pending_d = pending_q + 3'd1;
            2'b01:   pending_d = pending_q - 3'd1;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            dat_q     <= '{default: '0};
            pending_q <= '0;
        end else begin
            vld_q     <= vld_d;
            dat_q     <= dat_d;
            pending_q <= pending_d;
        end
    end

    assign data_valid = vld_q[LATENCY-1];
    assign data_out   = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : 16'h0000;
    assign pending    = pending_q;

endmodule
